mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 153 +++++++++++++++
 tb/tb_mem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Memory image loader: accepts 2**ADR_W input bytes, writes them to an
// external memory while keeping a running checksum, then reads the whole
// image back and compares the read-side sum against the write-side sum.
// All sequencing advances only on edges where the clken strobe is high.
module mem_loader #(
  parameter int ADR_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clken,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_BYTE   = 3'd1,
    S_WRITE       = 3'd2,
    S_VERIFY_ADDR = 3'd3,
    S_VERIFY_READ = 3'd4,
    S_CHECK       = 3'd5,
    S_DONE        = 3'd6,
    S_ERROR       = 3'd7
  } state_t;

  // Terminal count: the counters are compared before incrementing, so the
  // natural wrap back to zero on the last increment is harmless.
  localparam logic [ADR_W-1:0] LAST_ADR = '1;

  state_t              state_q, state_d;
  logic [ADR_W-1:0]    wcount_q, wcount_d;
  logic [ADR_W-1:0]    vcount_q, vcount_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic [DATA_W-1:0]   rsum_q, rsum_d;
  logic                mem_write_q, mem_write_d;
  logic [ADR_W-1:0]    mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  // Next-state and datapath: everything holds unless clken is high.
  always_comb begin
    state_d     = state_q;
    wcount_d    = wcount_q;
    vcount_d    = vcount_q;
    checksum_d  = checksum_q;
    rsum_d      = rsum_q;
    mem_write_d = mem_write_q;
    mem_adr_d   = mem_adr_q;
    mem_data_d  = mem_data_q;

    if (clken) begin
      // The write strobe lasts exactly one clken period; only an accepted
      // byte in WAIT_BYTE raises it again.
      mem_write_d = 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            wcount_d   = '0;
            vcount_d   = '0;
            checksum_d = '0;
            rsum_d     = '0;
            state_d    = S_WAIT_BYTE;
          end
        end
        S_WAIT_BYTE: begin
          if (in_valid) begin
            mem_data_d  = in_data;
            mem_adr_d   = wcount_q;
            mem_write_d = 1'b1;
            state_d     = S_WRITE;
          end
        end
        S_WRITE: begin
          checksum_d = checksum_q + mem_data_q;
          wcount_d   = wcount_q + 1'b1;
          state_d    = (wcount_q == LAST_ADR) ? S_VERIFY_ADDR : S_WAIT_BYTE;
        end
        S_VERIFY_ADDR: begin
          mem_adr_d = vcount_q;
          state_d   = S_VERIFY_READ;
        end
        S_VERIFY_READ: begin
          // Memory read data for mem_adr is valid by this edge.
          rsum_d   = rsum_q + mem_value;
          vcount_d = vcount_q + 1'b1;
          state_d  = (vcount_q == LAST_ADR) ? S_CHECK : S_VERIFY_ADDR;
        end
        S_CHECK: begin
          state_d = (rsum_q == checksum_q) ? S_DONE : S_ERROR;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_WAIT_BYTE) || (state_d == S_WRITE) ||
              (state_d == S_VERIFY_ADDR) || (state_d == S_VERIFY_READ) ||
              (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcount_q    <= '0;
      vcount_q    <= '0;
      checksum_q  <= '0;
      rsum_q      <= '0;
      mem_write_q <= 1'b0;
      mem_adr_q   <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcount_q    <= wcount_d;
      vcount_q    <= vcount_d;
      checksum_q  <= checksum_d;
      rsum_q      <= rsum_d;
      mem_write_q <= mem_write_d;
      mem_adr_q   <= mem_adr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = (state_q == S_WAIT_BYTE) && clken;
  assign mem_write = mem_write_q;
  assign mem_adr   = mem_adr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: clken every 10 sysclk cycles, a 16x8 memory model,
// a write scoreboard fed by the driver and drained by a monitor, and a
// reference model that predicts checksum and pass/fail from the byte list.
module tb_mem_loader;

  logic       sysclk = 1'b0;
  logic       reset, clken, start, in_valid;
  logic [7:0] in_data, mem_data, mem_value, checksum;
  logic [3:0] mem_adr;
  logic       in_ready, mem_write, busy, done, error;

  always #5 sysclk = ~sysclk;

  // Clock-enable strobe: one sysclk cycle in every ten.
  logic [3:0] ce_cnt = 4'd0;
  initial clken = 1'b0;
  always @(posedge sysclk) begin
    ce_cnt <= (ce_cnt == 4'd9) ? 4'd0 : ce_cnt + 4'd1;
    clken  <= (ce_cnt == 4'd9);
  end

  // Memory model: writes on clken&&write, combinational read with an
  // optional forced-zero fault on address 7.
  logic [7:0] mem [16];
  bit         corrupt7 = 1'b0;
  always @(posedge sysclk) if (clken && mem_write) mem[mem_adr] <= mem_data;
  assign mem_value = (corrupt7 && mem_adr == 4'd7) ? 8'h00 : mem[mem_adr];

  mem_loader #(.ADR_W(4), .DATA_W(8)) dut (
    .sysclk(sysclk), .reset(reset), .clken(clken), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_write(mem_write), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_value(mem_value), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  typedef struct packed {
    logic [3:0] adr;
    logic [7:0] dat;
  } wr_t;

  wr_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         write_cnt = 0;
  logic [7:0] load_bytes [16];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every write the memory will take, and
  // checks that nothing moves across an edge without clken.
  task automatic monitor();
    bit         snap_ce, snap_rst;
    logic [7:0] s_adr, s_dat, s_sum;
    logic       s_mw, s_busy, s_done, s_err;
    snap_ce  = 1'b1;
    snap_rst = 1'b1;
    forever begin
      @(negedge sysclk);
      #1;
      if (!snap_ce && !snap_rst) begin
        checks++;
        if ({s_mw, s_adr, s_dat, s_sum, s_busy, s_done, s_err} !==
            {mem_write, 4'h0, mem_adr, mem_data, checksum, busy, done, error}) begin
          errors++;
          $display("FAIL hold_without_clken: outputs changed at %0t", $time);
        end
      end
      if (clken && mem_write) begin
        write_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: adr=%0d data=0x%0h with none expected", mem_adr, mem_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({mem_adr, mem_data} !== e) begin
            errors++;
            $display("FAIL write: got adr=%0d data=0x%0h expected adr=%0d data=0x%0h",
                     mem_adr, mem_data, e.adr, e.dat);
          end
        end
      end
      snap_ce  = clken;
      snap_rst = reset;
      s_mw = mem_write; s_adr = {4'h0, mem_adr}; s_dat = mem_data; s_sum = checksum;
      s_busy = busy; s_done = done; s_err = error;
    end
  endtask

  // Return at the negedge preceding the next clken edge.
  task automatic wait_ce();
    do @(negedge sysclk); while (!clken);
  endtask

  // Return at the negedge preceding the next byte-accepting edge.
  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!in_ready && n < 400);
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic do_start();
    wait_ce();
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_byte(input int i);
    wait_ready();
    in_valid = 1'b1;
    in_data  = load_bytes[i];
    exp_q.push_back(wr_t'{adr: 4'(i), dat: load_bytes[i]});
    @(negedge sysclk);
  endtask

  // One full load; the expected result comes from the byte list alone.
  task automatic run_load(input int gap_at, input int gap_len, input int start_at, input bit corrupt);
    int  base, n, wsum, rsum;
    bit  rdy_bad;
    corrupt7 = corrupt;
    base = write_cnt;
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at && gap_len > 0) begin
        in_valid = 1'b0;
        repeat (gap_len) begin
          wait_ready();
          @(negedge sysclk);
        end
      end
      if (i == start_at) begin
        wait_ce();
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
      end
      send_byte(i);
    end
    in_valid = 1'b0;
    rdy_bad  = 1'b0;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(negedge sysclk);
      if (in_ready) rdy_bad = 1'b1;
      n++;
    end
    wsum = 0;
    rsum = 0;
    for (int i = 0; i < 16; i++) begin
      wsum += load_bytes[i];
      rsum += (corrupt && i == 7) ? 0 : load_bytes[i];
    end
    wsum = wsum % 256;
    rsum = rsum % 256;
    chk("load_finished", int'(n < 2000), 1);
    chk("in_ready_after_last", rdy_bad, 0);
    chk("checksum", checksum, wsum);
    chk("done", done, int'(rsum == wsum));
    chk("error", error, int'(rsum != wsum));
    chk("busy_at_end", busy, 0);
    chk("write_count", write_cnt - base, 16);
    chk("scoreboard_empty", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], load_bytes[i]);
    $display("load: corrupt=%0d gap_at=%0d gap_len=%0d start_at=%0d checksum=0x%0h done=%0d error=%0d",
             corrupt, gap_at, gap_len, start_at, checksum, done, error);
  endtask

  // Reset lands on the edge where the write strobe for byte 9 is high.
  task automatic run_reset_mid();
    int base;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    corrupt7 = 1'b0;
    base = write_cnt;
    do_start();
    for (int i = 0; i < 10; i++) send_byte(i);
    wait_ce();
    chk("mem_write_before_reset", mem_write, 1);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge sysclk);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_data", mem_data, 0);
    reset = 1'b0;
    chk("rst_write_count", write_cnt - base, 10);
    chk("rst_scoreboard_empty", exp_q.size(), 0);
    $display("reset mid-write: writes=%0d checksum=0x%0h busy=%0d", write_cnt - base, checksum, busy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    fork
      monitor();
    join_none
    repeat (25) @(negedge sysclk);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_adr", mem_adr, 0);
    chk("reset_mem_data", mem_data, 0);
    chk("reset_checksum", checksum, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 1'b0;

    // Ramp 0x00..0x0F: checksum 0x78, pass.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(i);
    run_load(-1, 0, -1, 1'b0);
    // All 0xFF: checksum wraps to 0xF0.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'hFF;
    run_load(-1, 0, -1, 1'b0);
    // Three idle clken periods between bytes 5 and 6.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    run_load(6, 3, -1, 1'b0);
    // Forced read fault on address 7: error expected.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(i);
    run_load(-1, 0, -1, 1'b1);
    // Start pulsed after byte 3 must be ignored (restart from ERROR checked too).
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    run_load(-1, 0, 4, 1'b0);
    // Reset mid-write, then reload from address 0.
    run_reset_mid();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    run_load(-1, 0, -1, 1'b0);
    // Randomized loads with random gaps and ignored start pulses.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
      run_load(int'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 15)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
